// File: rtl/ps2_kbd_pkg.sv
// Shared FSM type, scan-code constants and the set-2 to ASCII lookup used by the
// PS/2 scan-code decoder.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} kbd_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam logic [7:0] ASCII_UP    = 8'h80;
    localparam logic [7:0] ASCII_DOWN  = 8'h81;
    localparam logic [7:0] ASCII_LEFT  = 8'h82;
    localparam logic [7:0] ASCII_RIGHT = 8'h83;

    // Keyboard status/ack bytes and the Pause lead-in carry no key meaning.
    function automatic logic is_ignored(input logic [7:0] code);
        return code inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE};
    endfunction

    // Each entry is {lower, upper}; unmapped codes return 0.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [15:0] lh;
        case (code)
            8'h1C: lh = 16'h6141;  8'h32: lh = 16'h6242;  8'h21: lh = 16'h6343;
            8'h23: lh = 16'h6444;  8'h24: lh = 16'h6545;  8'h2B: lh = 16'h6646;
            8'h34: lh = 16'h6747;  8'h33: lh = 16'h6848;  8'h43: lh = 16'h6949;
            8'h3B: lh = 16'h6A4A;  8'h42: lh = 16'h6B4B;  8'h4B: lh = 16'h6C4C;
            8'h3A: lh = 16'h6D4D;  8'h31: lh = 16'h6E4E;  8'h44: lh = 16'h6F4F;
            8'h4D: lh = 16'h7050;  8'h15: lh = 16'h7151;  8'h2D: lh = 16'h7252;
            8'h1B: lh = 16'h7353;  8'h2C: lh = 16'h7454;  8'h3C: lh = 16'h7555;
            8'h2A: lh = 16'h7656;  8'h1D: lh = 16'h7757;  8'h22: lh = 16'h7858;
            8'h35: lh = 16'h7959;  8'h1A: lh = 16'h7A5A;
            8'h45: lh = 16'h3029;  8'h16: lh = 16'h3121;  8'h1E: lh = 16'h3240;
            8'h26: lh = 16'h3323;  8'h25: lh = 16'h3424;  8'h2E: lh = 16'h3525;
            8'h36: lh = 16'h365E;  8'h3D: lh = 16'h3726;  8'h3E: lh = 16'h382A;
            8'h46: lh = 16'h3928;
            8'h29: lh = 16'h2020;  8'h5A: lh = 16'h0D0D;  8'h66: lh = 16'h0808;
            8'h0D: lh = 16'h0909;  8'h76: lh = 16'h1B1B;
            8'h0E: lh = 16'h607E;  8'h4E: lh = 16'h2D5F;  8'h55: lh = 16'h3D2B;
            8'h54: lh = 16'h5B7B;  8'h5B: lh = 16'h5D7D;  8'h5D: lh = 16'h5C7C;
            8'h4C: lh = 16'h3B3A;  8'h52: lh = 16'h2722;  8'h41: lh = 16'h2C3C;
            8'h49: lh = 16'h2E3E;  8'h4A: lh = 16'h2F3F;
            default: lh = 16'h0000;
        endcase
        return shift ? lh[7:0] : lh[15:8];
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Valid/ready character channel between the scan-code decoder and the CPU keyboard register.
interface ps2_scancode_decoder_if;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_data, output key_valid, input key_ready);
    modport slave  (input key_data, input key_valid, output key_ready);
endinterface

// File: rtl/kbd_char_fifo.sv
// Generic first-word fall-through synchronous FIFO. A write while full is dropped unless
// a pop happens in the same cycle; a dropped write raises overflow_o for one cycle.
module kbd_char_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             overflow_o
);
    localparam int unsigned AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    always_comb begin
        pop        = rd_en_i && (count_q != '0);
        push       = wr_en_i && ((count_q != FullCnt) || pop);
        overflow_d = wr_en_i && !push;
        wr_ptr_d   = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + (AddrW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign valid_o    = (count_q != '0);
    assign rd_data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with modifier tracking and a character FIFO.
// Define PS2_CAPSLOCK_EN to add the Caps Lock toggle on scan code 58.
module ps2_scancode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    decoded_key,
    input  logic                          read_key,
    ps2_scancode_decoder_if.master        key_if,
    output logic                          overflow,
    output logic [2:0]                    mod_state
);
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;
    logic [2:0] key_sync_q, key_sync_d;
    logic       byte_stb;
    kbd_state_e state_q, state_d;
    logic       shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
    logic       is_make, is_brk, is_ext, is_shift_key, is_letter, upper_sel;
    logic [7:0] lower_code, char_code;
    logic       char_wr;

    assign rst_int_n = rst_sync_q[1];
    // Bits [1:0] are the synchronizer; bit 2 only remembers the previous synced level.
    assign byte_stb  = key_sync_q[1] && !key_sync_q[2];

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        key_sync_d = {key_sync_q[1:0], read_key};
        state_d    = state_q;
        is_make    = 1'b0;
        is_brk     = 1'b0;
        is_ext     = 1'b0;
        if (byte_stb) begin
            unique case (state_q)
                StIdle: begin
                    if (decoded_key == SC_EXT) state_d = StExt;
                    else if (decoded_key == SC_BRK) state_d = StBrk;
                    else if (!is_ignored(decoded_key)) is_make = 1'b1;
                end
                StExt: begin
                    if (decoded_key == SC_BRK) begin
                        state_d = StExtBrk;
                    end else if (decoded_key != SC_EXT) begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    is_brk  = 1'b1;
                    state_d = StIdle;
                end
                StExtBrk: begin
                    is_brk  = 1'b1;
                    is_ext  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        is_shift_key = !is_ext && ((decoded_key == SC_LSHIFT) || (decoded_key == SC_RSHIFT));
        shift_d      = shift_q;
        ctrl_d       = ctrl_q;
        if (is_make && is_shift_key) shift_d = 1'b1;
        if (is_brk && is_shift_key) shift_d = 1'b0;
        if (is_make && (decoded_key == SC_CTRL)) ctrl_d = 1'b1;
        if (is_brk && (decoded_key == SC_CTRL)) ctrl_d = 1'b0;
`ifdef PS2_CAPSLOCK_EN
        caps_d = caps_q;
        if (is_make && !is_ext && (decoded_key == SC_CAPS)) caps_d = !caps_q;
`else
        caps_d = 1'b0;
`endif

        lower_code = scan_to_ascii(decoded_key, 1'b0);
        is_letter  = (lower_code >= 8'h61) && (lower_code <= 8'h7A);
        // Caps only affects letters; punctuation and digits follow Shift alone.
        upper_sel  = is_letter ? (shift_q ^ caps_q) : shift_q;
        char_code  = '0;
        if (is_make && is_ext) begin
            case (decoded_key)
                SC_UP:    char_code = ASCII_UP;
                SC_DOWN:  char_code = ASCII_DOWN;
                SC_LEFT:  char_code = ASCII_LEFT;
                SC_RIGHT: char_code = ASCII_RIGHT;
                default:  char_code = '0;
            endcase
        end else if (is_make) begin
            if (ctrl_q && is_letter) char_code = lower_code & 8'h1F;
            else char_code = scan_to_ascii(decoded_key, upper_sel);
        end
        char_wr = (char_code != 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else rst_sync_q <= rst_sync_d;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            key_sync_q <= '0;
            state_q    <= StIdle;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            caps_q     <= 1'b0;
        end else begin
            key_sync_q <= key_sync_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            caps_q     <= caps_d;
        end
    end

    assign mod_state = {caps_q, ctrl_q, shift_q};

    kbd_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .wr_en_i    (char_wr),
        .wr_data_i  (char_code),
        .rd_en_i    (key_if.key_ready),
        .rd_data_o  (key_if.key_data),
        .valid_o    (key_if.key_valid),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: table-driven sequences, FIFO corner cases
// and random byte streams against a prefix-flag/lookup-table reference model.
module tb_ps2_scancode_decoder;

`ifdef PS2_CAPSLOCK_EN
    localparam bit CapsEn = 1'b1;
`else
    localparam bit CapsEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] decoded_key = 8'h00;
    logic       read_key = 1'b0;
    logic       overflow;
    logic [2:0] mod_state;

    ps2_scancode_decoder_if key_if ();

    ps2_scancode_decoder #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .decoded_key (decoded_key),
        .read_key    (read_key),
        .key_if      (key_if),
        .overflow    (overflow),
        .mod_state   (mod_state)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: every accepted character and every overflow pulse.
    logic [7:0] got[$];
    int         ovf_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && key_if.key_valid && key_if.key_ready) got.push_back(key_if.key_data);
        if (overflow) ovf_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        decoded_key = b;
        read_key    = 1'b1;
        repeat (4) @(negedge clk);
        read_key = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Reference model: character tables built from strings, prefixes kept as two flags.
    logic [7:0] lo_tbl [256];
    logic [7:0] hi_tbl [256];
    logic [7:0] let_c [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_c [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                               8'h46};
    logic [7:0] pun_c [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
                               8'h49, 8'h4A};
    logic [7:0] pun_lo [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
                                8'h2E, 8'h2F};
    logic [7:0] pun_hi [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
                                8'h3E, 8'h3F};
    logic [7:0] spc_c [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] spc_a [5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    task automatic build_tables();
        string let_s = "abcdefghijklmnopqrstuvwxyz";
        string dig_lo = "0123456789";
        string dig_hi = ")!@#$%^&*(";
        for (int i = 0; i < 256; i++) begin
            lo_tbl[i] = 8'h00;
            hi_tbl[i] = 8'h00;
        end
        for (int i = 0; i < 26; i++) begin
            lo_tbl[let_c[i]] = let_s[i];
            hi_tbl[let_c[i]] = let_s[i] - 8'd32;
        end
        for (int i = 0; i < 10; i++) begin
            lo_tbl[dig_c[i]] = dig_lo[i];
            hi_tbl[dig_c[i]] = dig_hi[i];
        end
        for (int i = 0; i < 11; i++) begin
            lo_tbl[pun_c[i]] = pun_lo[i];
            hi_tbl[pun_c[i]] = pun_hi[i];
        end
        for (int i = 0; i < 5; i++) begin
            lo_tbl[spc_c[i]] = spc_a[i];
            hi_tbl[spc_c[i]] = spc_a[i];
        end
    endtask

    bit         m_ext, m_brk, m_shift, m_ctrl, m_caps;
    logic [7:0] exp_q[$];

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] lo;
        bit         letter;
        if (m_brk) begin
            if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = 1'b0;
            if (b == 8'h14) m_ctrl = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!m_ext && (b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE})) begin
            m_ext = 1'b0;
        end else begin
            if (m_ext) begin
                if (b == 8'h75) exp_q.push_back(8'h80);
                else if (b == 8'h72) exp_q.push_back(8'h81);
                else if (b == 8'h6B) exp_q.push_back(8'h82);
                else if (b == 8'h74) exp_q.push_back(8'h83);
                else if (b == 8'h14) m_ctrl = 1'b1;
            end else if (b == 8'h12 || b == 8'h59) begin
                m_shift = 1'b1;
            end else if (b == 8'h14) begin
                m_ctrl = 1'b1;
            end else if (b == 8'h58 && CapsEn) begin
                m_caps = !m_caps;
            end else if (lo_tbl[b] != 8'h00) begin
                lo     = lo_tbl[b];
                letter = (lo >= 8'h61 && lo <= 8'h7A);
                if (letter && m_ctrl) exp_q.push_back(lo & 8'h1F);
                else if (letter) exp_q.push_back((m_shift ^ m_caps) ? hi_tbl[b] : lo);
                else exp_q.push_back(m_shift ? hi_tbl[b] : lo);
            end
            m_ext = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] seq;
        int          n;
        int          exp_n;
        logic [7:0]  exp_ch;
        logic [2:0]  exp_mod;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] s, input int n, input int en,
                                input logic [7:0] ch, input logic [2:0] m);
        vec_t v;
        v.seq = s; v.n = n; v.exp_n = en; v.exp_ch = ch; v.exp_mod = m;
        return v;
    endfunction

    vec_t       vecs[$];
    logic [7:0] pool [31] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h4E,
                              8'h54, 8'h4A, 8'h52, 8'h12, 8'h59, 8'h14, 8'hE0, 8'hF0, 8'h58,
                              8'hE1, 8'hAA, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h71, 8'h0D, 8'h76,
                              8'h41, 8'h49, 8'h1A, 8'h15};

    initial begin
        int         base;
        int         ovf0;
        logic [7:0] b;
        key_if.key_ready = 1'b1;
        build_tables();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst key_valid", key_if.key_valid, 0);
        check("rst key_data", key_if.key_data, 0);
        check("rst overflow", overflow, 0);
        check("rst mod_state", mod_state, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Latency: char written on the 3rd edge after read_key is first sampled high.
        @(posedge clk); #1 key_if.key_ready = 1'b0;
        @(negedge clk);
        decoded_key = 8'h1C;
        read_key    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat valid after 2 edges", key_if.key_valid, 0);
        @(posedge clk); #1;
        check("lat valid after 3 edges", key_if.key_valid, 1);
        check("lat data", key_if.key_data, 8'h61);
        read_key = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 key_if.key_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("lat drained", key_if.key_valid, 0);

        // Table-driven sequences; modifier state carries from one row to the next.
        vecs.push_back(mk(32'h1C000000, 1, 1, 8'h61, 3'd0));
        vecs.push_back(mk(32'hF01C0000, 2, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'h12000000, 1, 0, 8'h00, 3'd1));
        vecs.push_back(mk(32'h1C000000, 1, 1, 8'h41, 3'd1));
        vecs.push_back(mk(32'hF01C0000, 2, 0, 8'h00, 3'd1));
        vecs.push_back(mk(32'hF0120000, 2, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'h1C000000, 1, 1, 8'h61, 3'd0));
        vecs.push_back(mk(32'hE0750000, 2, 1, 8'h80, 3'd0));
        vecs.push_back(mk(32'hE0F07500, 3, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'hE0140000, 2, 0, 8'h00, 3'd2));
        vecs.push_back(mk(32'h21000000, 1, 1, 8'h03, 3'd2));
        vecs.push_back(mk(32'hE0F01400, 3, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'h59160000, 2, 1, 8'h21, 3'd1));
        vecs.push_back(mk(32'hF0595A00, 3, 1, 8'h0D, 3'd0));
        vecs.push_back(mk(32'hE1AAFA00, 3, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'hE0720000, 2, 1, 8'h81, 3'd0));
        vecs.push_back(mk(32'hE06B0000, 2, 1, 8'h82, 3'd0));
        vecs.push_back(mk(32'hE0740000, 2, 1, 8'h83, 3'd0));
        vecs.push_back(mk(32'h4E000000, 1, 1, 8'h2D, 3'd0));
        vecs.push_back(mk(32'h71000000, 1, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'h12520000, 2, 1, 8'h22, 3'd1));
        vecs.push_back(mk(32'hF0120000, 2, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'hE0E07500, 3, 1, 8'h80, 3'd0));
`ifdef PS2_CAPSLOCK_EN
        vecs.push_back(mk(32'h58000000, 1, 0, 8'h00, 3'd4));
        vecs.push_back(mk(32'h1C000000, 1, 1, 8'h41, 3'd4));
        vecs.push_back(mk(32'h16000000, 1, 1, 8'h31, 3'd4));
        vecs.push_back(mk(32'h121C0000, 2, 1, 8'h61, 3'd5));
        vecs.push_back(mk(32'hF012581C, 4, 1, 8'h61, 3'd0));
`else
        vecs.push_back(mk(32'h58000000, 1, 0, 8'h00, 3'd0));
        vecs.push_back(mk(32'h1C000000, 1, 1, 8'h61, 3'd0));
        vecs.push_back(mk(32'h16000000, 1, 1, 8'h31, 3'd0));
        vecs.push_back(mk(32'h121C0000, 2, 1, 8'h41, 3'd1));
        vecs.push_back(mk(32'hF012581C, 4, 1, 8'h61, 3'd0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            base = got.size();
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].seq[31 - 8 * k -: 8]);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d count", i), got.size() - base, vecs[i].exp_n);
            if (vecs[i].exp_n == 1 && got.size() > base)
                check($sformatf("vec%0d char", i), got[base], vecs[i].exp_ch);
            check($sformatf("vec%0d mod", i), mod_state, vecs[i].exp_mod);
        end

        // FIFO full, overflow, push+pop at full, then drain in order.
        @(posedge clk); #1 key_if.key_ready = 1'b0;
        ovf0 = ovf_cnt;
        base = got.size();
        for (int k = 0; k < 8; k++) send_byte(8'h16);
        check("ovf none at 8", ovf_cnt - ovf0, 0);
        send_byte(8'h16);
        check("ovf pulse on 9th", ovf_cnt - ovf0, 1);
        check("full valid", key_if.key_valid, 1);
        @(negedge clk);
        decoded_key = 8'h1E;
        read_key    = 1'b1;
        @(posedge clk);
        @(posedge clk); #2 key_if.key_ready = 1'b1;
        @(posedge clk); #2 key_if.key_ready = 1'b0;
        read_key = 1'b0;
        repeat (6) @(negedge clk);
        check("push+pop at full no ovf", ovf_cnt - ovf0, 1);
        @(posedge clk); #1 key_if.key_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("full drain count", got.size() - base, 9);
        for (int k = 0; k < 9; k++) begin
            if (got.size() > base + k)
                check($sformatf("full drain %0d", k), got[base + k], (k == 8) ? 8'h32 : 8'h31);
        end
        check("full drained valid", key_if.key_valid, 0);

        // Reset mid-sequence: prefix, modifiers and FIFO contents are discarded.
        @(posedge clk); #1 key_if.key_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'h12);
        send_byte(8'hE0);
        check("pre-rst valid", key_if.key_valid, 1);
        check("pre-rst mod", mod_state, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-rst valid", key_if.key_valid, 0);
        check("mid-rst data", key_if.key_data, 0);
        check("mid-rst overflow", overflow, 0);
        check("mid-rst mod", mod_state, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        key_if.key_ready = 1'b1;
        repeat (5) @(negedge clk);
        base = got.size();
        send_byte(8'h75);
        check("post-rst 75 no char", got.size() - base, 0);
        send_byte(8'h1C);
        check("post-rst idle count", got.size() - base, 1);
        if (got.size() > base) check("post-rst idle char", got[base], 8'h61);

        // Random byte stream against the reference model.
        m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
        ovf0 = ovf_cnt;
        base = got.size();
        for (int n = 0; n < 300; n++) begin
            b = pool[$urandom_range(0, 30)];
            send_byte(b);
            model_byte(b);
            check($sformatf("rnd%0d mod", n), mod_state, {m_caps, m_ctrl, m_shift});
        end
        repeat (4) @(negedge clk);
        check("rnd count", got.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (got.size() > base + k) check($sformatf("rnd char %0d", k), got[base + k], exp_q[k]);
        end
        check("rnd no overflow", ovf_cnt - ovf0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
